// File: rtl/merge_stream_r.sv
// Two-list loader feeding a registered Batcher odd-even merge network with valid/ready output.
// Optional MERGE_IDX_EN: tags each key with its source position, making the merge stable and exposing idx.
module merge_stream_r #(
   parameter int WIDTH = 3,
   parameter int N     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N*WIDTH-1:0]       ina,
   input  logic [N*WIDTH-1:0]       inb,
   input  logic [1:0]               load,
   input  logic                     desc,
   output logic [1:0]               in_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
`ifdef MERGE_IDX_EN
   output logic [2*N*$clog2(2*N)-1:0] idx,
`endif
   output logic [2*N*WIDTH-1:0]     c
);

   localparam int S  = $clog2(2*N);
   localparam int DW = 2*N*WIDTH;
`ifdef MERGE_IDX_EN
   localparam int IW = $clog2(2*N);
   localparam int TW = 2*N*IW;
`endif

   // Comparator role of element e in a layer with span k: 0 = pass, 1 = low end, 2 = high end.
   function automatic int role_of(input int e, input int k, input int n2);
      if (2*k == n2) return (e < k) ? 1 : 2;
      if (e < k || e >= n2 - k) return 0;
      return (((e - k) % (2*k)) < k) ? 1 : 2;
   endfunction

`ifdef MERGE_IDX_EN
   function automatic logic in_order(input logic [WIDTH-1:0] lk, input logic [WIDTH-1:0] hk,
                                     input logic [IW-1:0] lt, input logic [IW-1:0] ht,
                                     input logic d);
      if (lk == hk) return (lt <= ht);
      return d ? (lk > hk) : (lk < hk);
   endfunction
`else
   function automatic logic in_order(input logic [WIDTH-1:0] lk, input logic [WIDTH-1:0] hk,
                                     input logic d);
      return d ? (lk >= hk) : (lk <= hk);
   endfunction
`endif

   logic [N*WIDTH-1:0] a_reg, b_reg;
   logic               a_full_reg, b_full_reg;
   logic               en, launch;

   // Register level 0 holds the raw {B,A} job; levels 1..S each apply one comparator layer.
   logic [DW-1:0]      key_reg  [0:S];
   logic [DW-1:0]      key_next [1:S];
   logic [S:0]         vld_reg;
   logic               desc_reg [0:S-1];
`ifdef MERGE_IDX_EN
   logic [TW-1:0]      tag_reg  [0:S];
   logic [TW-1:0]      tag_next [1:S];
   logic [TW-1:0]      init_tag;
`endif

   assign in_ready  = ~{b_full_reg, a_full_reg};
   assign out_valid = vld_reg[S];
   assign c         = key_reg[S];
`ifdef MERGE_IDX_EN
   assign idx       = tag_reg[S];
`endif
   assign en        = !(out_valid && !out_ready);
   assign launch    = a_full_reg && b_full_reg && en;

   genvar gi, gj;

`ifdef MERGE_IDX_EN
   for (gi = 0; gi < 2*N; gi++) begin : g_init_tag
      assign init_tag[gi*IW +: IW] = IW'(gi);
   end
`endif

   for (gj = 1; gj <= S; gj++) begin : g_stage
      localparam int K = N >> (gj - 1);
      for (gi = 0; gi < 2*N; gi++) begin : g_node
         localparam int ROLE = role_of(gi, K, 2*N);
         if (ROLE == 0) begin : g_pass
            assign key_next[gj][gi*WIDTH +: WIDTH] = key_reg[gj-1][gi*WIDTH +: WIDTH];
`ifdef MERGE_IDX_EN
            assign tag_next[gj][gi*IW +: IW] = tag_reg[gj-1][gi*IW +: IW];
`endif
         end else begin : g_cmp
            localparam int LO = (ROLE == 2) ? gi - K : gi;
            localparam int HI = (ROLE == 1) ? gi + K : gi;
            logic [WIDTH-1:0] lk, hk;
            logic             keep;
            assign lk = key_reg[gj-1][LO*WIDTH +: WIDTH];
            assign hk = key_reg[gj-1][HI*WIDTH +: WIDTH];
`ifdef MERGE_IDX_EN
            logic [IW-1:0] lt, ht;
            assign lt   = tag_reg[gj-1][LO*IW +: IW];
            assign ht   = tag_reg[gj-1][HI*IW +: IW];
            assign keep = in_order(lk, hk, lt, ht, desc_reg[gj-1]);
            if (ROLE == 1) begin : g_lo_tag
               assign tag_next[gj][gi*IW +: IW] = keep ? lt : ht;
            end else begin : g_hi_tag
               assign tag_next[gj][gi*IW +: IW] = keep ? ht : lt;
            end
`else
            assign keep = in_order(lk, hk, desc_reg[gj-1]);
`endif
            if (ROLE == 1) begin : g_lo
               assign key_next[gj][gi*WIDTH +: WIDTH] = keep ? lk : hk;
            end else begin : g_hi
               assign key_next[gj][gi*WIDTH +: WIDTH] = keep ? hk : lk;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         a_reg      <= '0;
         b_reg      <= '0;
         a_full_reg <= 1'b0;
         b_full_reg <= 1'b0;
         vld_reg    <= '0;
         for (int s = 0; s <= S; s++) begin
            key_reg[s] <= '0;
`ifdef MERGE_IDX_EN
            tag_reg[s] <= '0;
`endif
         end
         for (int s = 0; s < S; s++) desc_reg[s] <= 1'b0;
      end else begin
         // Slots are full on their launch edge, so a refill can never race the clear.
         if (load[0] && !a_full_reg) begin
            a_reg      <= ina;
            a_full_reg <= 1'b1;
         end else if (launch) begin
            a_full_reg <= 1'b0;
         end
         if (load[1] && !b_full_reg) begin
            b_reg      <= inb;
            b_full_reg <= 1'b1;
         end else if (launch) begin
            b_full_reg <= 1'b0;
         end

         if (en) begin
            vld_reg[0] <= launch;
            if (launch) begin
               key_reg[0]  <= {b_reg, a_reg};
               desc_reg[0] <= desc;
`ifdef MERGE_IDX_EN
               tag_reg[0]  <= init_tag;
`endif
            end
            // Data only moves with a valid job so c keeps the last result when idle.
            for (int s = 1; s <= S; s++) begin
               vld_reg[s] <= vld_reg[s-1];
               if (vld_reg[s-1]) begin
                  key_reg[s] <= key_next[s];
`ifdef MERGE_IDX_EN
                  tag_reg[s] <= tag_next[s];
`endif
               end
            end
            for (int s = 1; s < S; s++) desc_reg[s] <= desc_reg[s-1];
         end
      end
   end

endmodule

// File: tb/tb_merge_stream_r.sv
// Scoreboard bench for merge_stream_r: a sorting model predicts each job, the monitor pops on every output transfer.
module tb_merge_stream_r;

   localparam int WIDTH = 3;
   localparam int N     = 8;
   localparam int IW    = 4;
   localparam int CW    = 2*N*WIDTH;
   localparam int TW    = 2*N*IW;

   typedef int arr8_t  [8];
   typedef int arr16_t [16];
   typedef struct {
      logic [CW-1:0] c;
      logic [TW-1:0] idx;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [N*WIDTH-1:0] ina, inb;
   logic [1:0]        load;
   logic              desc;
   logic [1:0]        in_ready;
   logic              out_valid;
   logic              out_ready;
   logic [CW-1:0]     c;
`ifdef MERGE_IDX_EN
   logic [TW-1:0]     idx;
`endif

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_sent   = 0;
   int   n_recv   = 0;
   bit   rnd_ready = 1'b0;

   always #5 clk = ~clk;

   merge_stream_r #(.WIDTH(WIDTH), .N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .ina       (ina),
      .inb       (inb),
      .load      (load),
      .desc      (desc),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef MERGE_IDX_EN
      .idx       (idx),
`endif
      .c         (c)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [N*WIDTH-1:0] pack8(input arr8_t v);
      logic [N*WIDTH-1:0] p;
      for (int i = 0; i < N; i++) p[i*WIDTH +: WIDTH] = v[i][WIDTH-1:0];
      return p;
   endfunction

   function automatic logic [CW-1:0] pack16(input arr16_t v);
      logic [CW-1:0] p;
      for (int i = 0; i < 2*N; i++) p[i*WIDTH +: WIDTH] = v[i][WIDTH-1:0];
      return p;
   endfunction

   // Stable insertion sort of the 16 tagged keys.
   function automatic exp_t model(input logic [N*WIDTH-1:0] a, input logic [N*WIDTH-1:0] b,
                                  input logic d);
      int   k [2*N];
      int   t [2*N];
      int   tmp;
      exp_t e;
      for (int i = 0; i < N; i++) begin
         k[i]   = int'(a[i*WIDTH +: WIDTH]);
         t[i]   = i;
         k[N+i] = int'(b[i*WIDTH +: WIDTH]);
         t[N+i] = N + i;
      end
      for (int i = 1; i < 2*N; i++) begin
         for (int j = i; j > 0; j--) begin
            if (d ? (k[j-1] < k[j]) : (k[j-1] > k[j])) begin
               tmp = k[j-1]; k[j-1] = k[j]; k[j] = tmp;
               tmp = t[j-1]; t[j-1] = t[j]; t[j] = tmp;
            end else begin
               break;
            end
         end
      end
      for (int i = 0; i < 2*N; i++) begin
         e.c[i*WIDTH +: WIDTH] = k[i][WIDTH-1:0];
         e.idx[i*IW +: IW]     = t[i][IW-1:0];
      end
      return e;
   endfunction

   function automatic arr8_t rand_list(input logic d);
      arr8_t v;
      int    tmp;
      for (int i = 0; i < N; i++) v[i] = int'($urandom_range(0, (1 << WIDTH) - 1));
      for (int i = 1; i < N; i++) begin
         for (int j = i; j > 0; j--) begin
            if (d ? (v[j-1] < v[j]) : (v[j-1] > v[j])) begin
               tmp = v[j-1]; v[j-1] = v[j]; v[j] = tmp;
            end
         end
      end
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_ready(input logic [1:0] m);
      int n = 0;
      while ((in_ready & m) != m && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) chk("ready_timeout", 128'(in_ready), 128'(m));
   endtask

   task automatic load_lists(input logic [1:0] m, input logic [N*WIDTH-1:0] a,
                             input logic [N*WIDTH-1:0] b, input logic d);
      wait_ready(m);
      ina  = a;
      inb  = b;
      desc = d;
      load = m;
      tick();
      load = 2'b00;
   endtask

   task automatic send(input logic [N*WIDTH-1:0] a, input logic [N*WIDTH-1:0] b, input logic d);
      sb_q.push_back(model(a, b, d));
      n_sent++;
      load_lists(2'b11, a, b, d);
   endtask

   task automatic send_exp(input logic [N*WIDTH-1:0] a, input logic [N*WIDTH-1:0] b,
                           input logic d, input logic [CW-1:0] cexp);
      exp_t e;
      e   = model(a, b, d);
      e.c = cexp;
      sb_q.push_back(e);
      n_sent++;
      load_lists(2'b11, a, b, d);
   endtask

   // Counts edges until out_valid is seen; 99 means it never came.
   task automatic wait_valid(output int lat);
      lat = 99;
      for (int n = 1; n <= 20; n++) begin
         tick();
         if (out_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((sb_q.size() != 0 || out_valid) && n < 500) begin
         tick();
         n++;
      end
      chk("drain", 128'(sb_q.size()), 128'd0);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_out", 128'(c), 128'hx);
         end else begin
            e = sb_q.pop_front();
            n_recv++;
            chk($sformatf("job%0d_c", n_recv), 128'(c), 128'(e.c));
`ifdef MERGE_IDX_EN
            chk($sformatf("job%0d_idx", n_recv), 128'(idx), 128'(e.idx));
`endif
            $display("job %0d out c=%0h", n_recv, c);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      arr8_t         a1, b1, a4, b4, a5, ra, rb;
      arr16_t        c1, c4;
      logic [CW-1:0] hold_c;
      logic          rd;
      int            lat, seen;

      a1 = '{0, 1, 1, 3, 5, 6, 7, 7};
      b1 = '{0, 2, 2, 3, 4, 4, 6, 7};
      c1 = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 6, 6, 7, 7, 7};
      a4 = '{7, 6, 5, 4, 3, 2, 1, 0};
      b4 = '{7, 7, 5, 5, 2, 2, 0, 0};
      c4 = '{7, 7, 7, 6, 5, 5, 5, 4, 3, 2, 2, 2, 1, 0, 0, 0};
      a5 = '{5, 5, 5, 5, 5, 5, 5, 5};

      rst = 1'b0; load = 2'b00; ina = '0; inb = '0; desc = 1'b0; out_ready = 1'b1;
      load = 2'b11;
      tick();
      tick();
      load = 2'b00;
      chk("rst_in_ready", 128'(in_ready), 128'd3);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_c", 128'(c), 128'd0);
      rst = 1'b1;
      tick();

      // Basic ascending merge and latency
      send_exp(pack8(a1), pack8(b1), 1'b0, pack16(c1));
      chk("t1_in_ready_full", 128'(in_ready), 128'd0);
      wait_valid(lat);
      chk("t1_latency", 128'(lat), 128'd5);
      tick();
      chk("t1_single_cycle", 128'(out_valid), 128'd0);
      chk("t1_c_retained", 128'(c), 128'(pack16(c1)));

      // Partial load
      ra = rand_list(1'b0);
      rb = rand_list(1'b0);
      load_lists(2'b01, pack8(ra), pack8(rb), 1'b0);
      for (int i = 0; i < 10; i++) begin
         chk("t2_in_ready", 128'(in_ready), 128'd2);
         chk("t2_out_valid", 128'(out_valid), 128'd0);
         tick();
      end
      sb_q.push_back(model(pack8(ra), pack8(rb), 1'b0));
      n_sent++;
      load_lists(2'b10, pack8(ra), pack8(rb), 1'b0);
      wait_valid(lat);
      chk("t2_latency", 128'(lat), 128'd5);
      drain();

      // Backpressure with a second job captured during the stall
      out_ready = 1'b0;
      rd = 1'($urandom_range(0, 1));
      send(pack8(rand_list(rd)), pack8(rand_list(rd)), rd);
      wait_valid(lat);
      chk("t3_latency", 128'(lat), 128'd5);
      hold_c = c;
      rd = ~rd;
      send(pack8(rand_list(rd)), pack8(rand_list(rd)), rd);
      for (int i = 0; i < 4; i++) begin
         chk("t3_c_hold", 128'(c), 128'(hold_c));
         chk("t3_valid_hold", 128'(out_valid), 128'd1);
         chk("t3_in_ready", 128'(in_ready), 128'd0);
         tick();
      end
      out_ready = 1'b1;
      drain();

      // Descending merge
      send_exp(pack8(a4), pack8(b4), 1'b1, pack16(c4));
      drain();

      // Reset two cycles after launch
      send(pack8(rand_list(1'b0)), pack8(rand_list(1'b0)), 1'b0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      sb_q.delete();
      n_sent--;
      chk("t5_out_valid", 128'(out_valid), 128'd0);
      chk("t5_in_ready", 128'(in_ready), 128'd3);
      chk("t5_c", 128'(c), 128'd0);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (out_valid) seen++;
      end
      chk("t5_no_output", 128'(seen), 128'd0);
      send(pack8(rand_list(1'b1)), pack8(rand_list(1'b1)), 1'b1);
      drain();

      // All-equal keys in both orders
      send(pack8(a5), pack8(a5), 1'b0);
      send(pack8(a5), pack8(a5), 1'b1);
      drain();

      // Random jobs with random backpressure
      rnd_ready = 1'b1;
      for (int j = 0; j < 12; j++) begin
         rd = 1'($urandom_range(0, 1));
         send(pack8(rand_list(rd)), pack8(rand_list(rd)), rd);
      end
      rnd_ready = 1'b0;
      out_ready = 1'b1;
      drain();

      chk("recv_count", 128'(n_recv), 128'(n_sent));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/merge_stream_r.md
Name: merge_stream_r

Overview:
Parametrised, pipelined successor to the fixed 8+8 register-load merger. It captures two sorted lists A and B of N keys each through per-list load handshakes, then merges them through a registered odd-even (Batcher) merge network of log2(2N) stages. The network supports ascending or descending order, selected per job. Output uses valid/ready backpressure, so it feeds downstream V2V sorter stages without dropping results.

Parameters:
WIDTH, 3, key width in bits (>=1)
N, 8, keys per input list; power of 2, >=2
S (localparam), log2(2N), number of merge pipeline stages (4 for N=8)
IW (localparam), log2(2N), index width (used only with MERGE_IDX_EN)

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, synchronous, active-low
ina  in  N*WIDTH  sorted list A; element 0 in LSBs
inb  in  N*WIDTH  sorted list B; element 0 in LSBs
load  in  2  bit0 = capture ina, bit1 = capture inb
desc  in  1  order for the job: 0 = ascending, 1 = descending; inputs must already be sorted in the same order
in_ready  out  2  bit k high = slot k empty, so load[k] will be accepted
out_valid  out  1  c holds a completed merge
out_ready  in  1  downstream accepts c
c  out  2*N*WIDTH  merged list; element 0 in LSBs (smallest if ascending)
idx  out  2*N*IW  original position of each c element (only with MERGE_IDX_EN)

Behaviour:
- Reset: one clock and a synchronous, active-low reset named rst. At any edge with rst=0:
  - a_full, b_full and all stage valid bits clear;
  - all stage data registers and c go to 0, and out_valid goes to 0;
  - in_ready = 2'b11, since it is combinational ~{b_full,a_full};
  - load is ignored.
  - A reset mid-job discards every in-flight job; no partial output is produced.
- Capture:
  - load[k]=1 with in_ready[k]=1 registers the list into slot k and sets k_full.
  - load[k]=1 with in_ready[k]=0 is ignored; the slot contents are unchanged.
  - Both bits may be loaded in the same cycle.
- Pipeline enable: en = !(out_valid && !out_ready). All stage registers and valid bits advance only when en=1. Bubbles are not compressed.
- Launch:
  - A job launches at an edge where a_full && b_full && en.
  - At that edge, stage 1 loads the network input {B,A} plus desc sampled at that edge. Both full flags clear.
  - A slot cannot be refilled on its launch edge. Back-to-back jobs therefore run at most one per 2 cycles.
- Stages:
  - Stage s (1..S) holds registered data, valid and desc.
  - Each comparator outputs min on L and max on H when desc=0, and swaps when desc=1.
  - c is the stage-S data register and out_valid is the stage-S valid bit.
- Latency: with no stall, out_valid rises S+1 edges after the edge that captured the second list (5 for N=8).
- Output hold: while out_valid=1 and out_ready=0, c, idx and out_valid stay stable. The transfer completes on an edge where out_valid && out_ready.
- Idle: after the last job drains, c retains the last value and out_valid=0.
- Arithmetic: keys are unsigned. Equal keys produce equal values. Without MERGE_IDX_EN the order among equal keys is not specified.
- Input precondition: unsorted input lists give an unspecified permutation. No error flag exists.

Optional Feature:
MERGE_IDX_EN
- Defined:
  - Each key is tagged with an IW-bit index: A[i] -> i, B[i] -> N+i.
  - Comparisons use {key, index}, with the index always compared ascending. This makes the merge stable: among equal keys, lower original index comes first.
  - The idx port carries the tags aligned with c and follows the same reset and hold rules.
- Undefined: the idx port and the tag registers are absent, and the tie order is unspecified.

Test Plan:
1. Basic ascending merge, WIDTH=3, N=8.
   - Stimulus: load=11, A={0,1,1,3,5,6,7,7}, B={0,2,2,3,4,4,6,7}, desc=0, out_ready=1.
   - Response: out_valid 5 cycles later with c={0,0,1,1,2,2,3,3,4,4,5,6,6,7,7,7}; out_valid is high for exactly 1 cycle.
2. Partial load.
   - Stimulus: load A only, then idle 10 cycles.
   - Response: in_ready=2'b10 and out_valid=0 throughout. Then load B -> out_valid 5 cycles after B's capture edge.
3. Backpressure.
   - Stimulus: hold out_ready=0 for 4 cycles while job 1 is valid; load job 2 meanwhile.
   - Response: c is stable for those 4 cycles and in_ready=2'b00 once job 2 is captured. After out_ready=1, job 2 appears in correct order and no data is lost.
4. Descending merge.
   - Stimulus: desc=1, A={7,6,5,4,3,2,1,0}, B={7,7,5,5,2,2,0,0}.
   - Response: c={7,7,7,6,5,5,5,4,3,2,2,2,1,0,0,0}.
5. Reset mid-job.
   - Stimulus: rst=0 for 1 cycle, 2 cycles after launch.
   - Response: out_valid stays 0 afterwards, in_ready=2'b11, c=0. A fresh job then completes normally.
6. Index tagging (MERGE_IDX_EN defined).
   - Stimulus: all 16 keys = 5.
   - Response: c is all 5s and idx={0,1,...,15} in order. For test 1's data, idx[0]=0 and idx[1]=8.
